// File: rtl/sap_mem_unit.sv
// sap_mem_unit: SAP memory stage with MAR, MDR, a 2**ADDR_W x DATA_W RAM
// driven by the sequencer's active-low strobes, and a byte-stream
// programming port that preloads RAM while the CPU is held off.
// Optional build macro: SAP_MEM_CLEAR_ON_RESET_EN (RAM cleared on reset).
module sap_mem_unit #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              mar_addr_load_n,
    input  logic              mar_mem_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar_q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [ADDR_W-1:0] prog_addr_d;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] ram [DEPTH];
    logic              cpu_mode;
    logic              prog_we;
    logic              cpu_we;

    // Programming FSM state and load-address register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            prog_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
        end
    end

    // Next state, programming handshake and CPU-mode qualifier
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        cpu_mode    = 1'b0;
        prog_ready  = 1'b0;
        prog_done   = 1'b0;
        prog_we     = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_mode = 1'b1;
                if (prog_mode) begin
                    state_d     = LOAD;
                    prog_addr_d = '0;
                end
            end
            LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid) begin
                    prog_we     = 1'b1;
                    prog_addr_d = prog_addr_q + ADDR_W'(1);
                    if (prog_addr_q == {ADDR_W{1'b1}}) begin
                        state_d = DONE;
                    end
                end
                // Abort wins: bytes already stored are kept
                if (!prog_mode) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                prog_done = 1'b1;
                if (!prog_mode) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_we  = cpu_mode & ~ram_load_n;
    assign bus_oe  = cpu_mode & ~ram_en_n;
    assign bus_out = bus_oe ? ram[mar_q] : '0;

    // MAR and MDR capture from the bus; strobes are ignored while programming
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else if (cpu_mode) begin
            if (!mar_addr_load_n) begin
                mar_q <= bus_in[ADDR_W-1:0];
            end
            if (!mar_mem_load_n) begin
                mdr_q <= bus_in;
            end
        end
    end

    // RAM write port; uses pre-edge MAR/MDR so same-edge loads do not race
    always_ff @(posedge clk) begin
        if (!resetn) begin
`ifdef SAP_MEM_CLEAR_ON_RESET_EN
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ram[ADDR_W'(i)] <= '0;
            end
`endif
        end else if (cpu_we) begin
            ram[mar_q] <= mdr_q;
        end else if (prog_we) begin
            ram[prog_addr_q] <= prog_data;
        end
    end

endmodule
